uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Serial console stage directly downstream of the CPU system's output-byte port; consumes every out_byte/out_byte_en strobe.
- Buffers strobed bytes in a small synchronous FIFO and transmits them as 8N1 UART frames (idle-high, LSB first) on a single tx line.
- Decouples firmware byte writes (one per cycle possible) from the slow serial rate, and flags drops on overflow.

Parameters:
- CLK_DIV, 868, clock cycles per serial bit (e.g. 100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  reset, asynchronous assert, active-low; synchronous deassert expected from the system.
- in_byte  input  8  byte to transmit; connects to system out_byte.
- in_byte_en  input  1  one-cycle write strobe; connects to system out_byte_en.
- tx  output  1  UART serial output, registered.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky flag: a strobed byte was dropped.

Behaviour:
- Reset (resetn low, asynchronous): tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0, read/write pointers=0. Reset mid-frame aborts the frame immediately; tx returns to 1 the same instant.
- FIFO write: on an edge with in_byte_en=1, in_byte is written when fifo_count<FIFO_DEPTH, or when fifo_count==FIFO_DEPTH and a pop occurs on the same edge.
- FIFO drop: otherwise the byte is discarded and overflow is set to 1. overflow stays 1 until reset. FIFO contents are unchanged on a drop.
- FIFO pop: happens only on the FSM IDLE->START or STOP->START transition. Pointers wrap modulo FIFO_DEPTH. fifo_count is +1 on push only, -1 on pop only, and unchanged on simultaneous push+pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count!=0 at the edge, pop the head into the shift register, set tx<=0, load baud counter to CLK_DIV-1, go to START.
  - START/DATA/STOP: the baud counter decrements every cycle. Each bit occupies exactly CLK_DIV cycles on tx.
  - START, counter==0: tx<=shift[0], bit index=0, reload counter, go to DATA.
  - DATA, counter==0: if bit index<7, shift right, tx<=next bit, bit index+1, reload. On bit index==7, tx<=1, reload, go to STOP.
  - STOP, counter==0: if fifo_count!=0, pop and start the next frame directly (tx<=0, go to START, no idle gap). Else go to IDLE with tx=1.
- Frame: exactly 10*CLK_DIV cycles (start=0, d0..d7, stop=1).
- Latency: a byte strobed into an empty, idle block at edge N gives tx falling at edge N+1 (one cycle in FIFO, then pop).
- busy = (FSM!=IDLE) || (fifo_count!=0). It is registered-state-derived and must be glitch-free.
- Byte order: bytes go out in strict write order. No reordering, no duplication.

Test Plan:
- Reset/idle (CLK_DIV=4, FIFO_DEPTH=4): hold resetn=0 for 3 cycles, release -> tx=1, busy=0, fifo_count=0, overflow=0. These values hold for 50 idle cycles.
- Single byte: strobe 0xA5 at edge N -> tx falls at N+1. Bit-period samples read 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each 4 cycles long. Frame is 40 cycles; busy drops at the end of stop.
- Back-to-back: strobe 0x01,0x02,0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap. fifo_count peaks at 2. Decoded bytes are 0x01,0x02,0x03.
- Overflow: while a frame is in flight, strobe 6 bytes 0x10..0x15 on consecutive cycles with FIFO_DEPTH=4 -> 0x10..0x13 are transmitted, 0x14 and 0x15 are dropped, overflow=1 and stays 1 after the FIFO drains.
- Push at full with pop: fill the FIFO to 4, then strobe 0x77 on the exact edge of STOP->START -> the byte is accepted, fifo_count remains 4, overflow stays 0, and 0x77 is transmitted last.
- Reset mid-frame: assert resetn low during data bit 3 of 0xFF -> tx=1 immediately (asynchronously), fifo_count=0. After release, nothing is transmitted until a new strobe.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-strobe input and UART status bundle for uart_tx_fifo.
// The system (master) drives the strobe. The serial stage (slave) returns
// the line and its status flags.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       in_byte;
  logic             in_byte_en;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output in_byte, in_byte_en,
    input  tx, busy, fifo_count, overflow
  );

  modport slave (
    input  in_byte, in_byte_en,
    output tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Serial console stage: buffers strobed bytes in a small FIFO and sends them
// as 8N1 UART frames (idle-high, LSB first). Frames follow each other with
// no idle gap. A byte strobed while the FIFO is full is dropped, and the
// sticky overflow flag is set.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            resetn,
  uart_tx_fifo_if.slave   bus
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic              pop_s;
  logic              push_s;
  logic              nonempty_s;
  logic              baud_zero_s;
  logic [7:0]        head_s;

  assign nonempty_s  = (count_q != {CNT_W{1'b0}});
  assign baud_zero_s = (baud_q == {BAUD_W{1'b0}});
  assign head_s      = mem_q[rd_ptr_q];

  // Frame sequencer: bit timing, shift register and the pop decision.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nonempty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          tx_d    = 1'b0;
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_zero_s) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          baud_d    = BAUD_RELOAD;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_zero_s) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_zero_s) begin
          if (nonempty_s) begin
            // Back-to-back frame: the next start bit follows the stop bit directly.
            pop_s   = 1'b1;
            shift_d = head_s;
            tx_d    = 1'b0;
            baud_d  = BAUD_RELOAD;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: accept/drop decision, pointers, occupancy and status.
  always_comb begin
    push_s     = bus.in_byte_en & ((count_q != DEPTH_C) | pop_s);
    overflow_d = overflow_q | (bus.in_byte_en & ~push_s);
    wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Derived from next-state values so the registered copy is glitch-free.
    busy_d = (state_d != S_IDLE) | (count_d != {CNT_W{1'b0}});
  end

  // FIFO storage: written on accepted strobes; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.in_byte;
    end
  end

  // State registers, cleared asynchronously so a reset aborts any frame at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      baud_q     <= {BAUD_W{1'b0}};
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (CLK_DIV=4, FIFO_DEPTH=4). A frame-timer reference
// model predicts the line and status every cycle. Accepted bytes are queued
// as expected frames. A UART decoder pops and compares each received frame.
module tb_uart_tx_fifo;
  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CD;

  logic clk;
  logic resetn;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         frame_left;
  logic [7:0] cur_byte;
  bit         m_ovf;
  int         m_sz0;
  bit         m_pop;
  bit         m_acc;

  // Decoder state.
  bit         in_frame;
  int         dcnt;
  int         dpos;
  logic [7:0] dbyte;
  int         rx_count;
  logic [7:0] last_rx;
  int         peak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (frame_left == 0) return 1'b1;
    k = (FRAME - frame_left) / CD;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_byte[k-1];
    return 1'b1;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a frame lasts FRAME cycles after each pop. A pop happens when bytes wait and the line is idle or in its last stop cycle.
  initial begin
    frame_left = 0;
    m_ovf      = 1'b0;
    cur_byte   = 8'h00;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        mq.delete();
        exp_q.delete();
        frame_left = 0;
        m_ovf      = 1'b0;
      end else begin
        m_sz0 = mq.size();
        m_pop = (m_sz0 != 0) && (frame_left <= 1);
        m_acc = bus.in_byte_en && ((m_sz0 < DEPTH) || m_pop);
        if (m_pop) begin
          cur_byte   = mq.pop_front();
          frame_left = FRAME;
        end else if (frame_left > 0) begin
          frame_left--;
        end
        if (m_acc) begin
          mq.push_back(bus.in_byte);
          exp_q.push_back(bus.in_byte);
        end else if (bus.in_byte_en) begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of line and status against the model.
  initial begin
    peak = 0;
    forever begin
      @(negedge clk);
      check("tx_cycle", 32'(bus.tx), 32'(exp_tx()));
      check("busy_cycle", 32'(bus.busy), 32'((frame_left != 0) || (mq.size() != 0)));
      check("count_cycle", 32'(bus.fifo_count), 32'(mq.size()));
      check("ovf_cycle", 32'(bus.overflow), 32'(m_ovf));
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end
  end

  // UART decoder monitor: samples mid-bit and compares each frame with the expected queue.
  initial begin
    in_frame = 1'b0;
    dcnt     = 0;
    rx_count = 0;
    last_rx  = 8'h00;
    dbyte    = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (bus.tx == 1'b0) begin
          in_frame = 1'b1;
          dcnt     = 1;
        end
      end else begin
        dcnt++;
      end
      if (in_frame) begin
        dpos = dcnt - 1;
        if ((dpos % CD) == (CD / 2)) begin
          if (dpos / CD == 0) check("start_bit", 32'(bus.tx), 32'd0);
          else if (dpos / CD <= 8) dbyte[dpos/CD-1] = bus.tx;
          else check("stop_bit", 32'(bus.tx), 32'd1);
        end
        if (dcnt == FRAME) begin
          in_frame = 1'b0;
          rx_count++;
          last_rx = dbyte;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rx_byte: got frame %0h, expected no frame", dbyte);
          end else begin
            check("rx_byte", 32'(dbyte), 32'(exp_q.pop_front()));
            total--;
          end
        end
      end
    end
  end

  task automatic drive(input logic en, input logic [7:0] b);
    @(negedge clk);
    bus.in_byte_en = en;
    bus.in_byte    = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    while ((frame_left != 0 || mq.size() != 0 || exp_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", 32'(w < 3000), 32'd1);
    @(negedge clk);
    check("drain_busy", 32'(bus.busy), 32'd0);
    check("drain_tx", 32'(bus.tx), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[10];
    int w;
    int rx0;
    pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    resetn         = 1'b0;
    bus.in_byte    = 8'h00;
    bus.in_byte_en = 1'b0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (50) @(negedge clk);
    check("idle_tx", 32'(bus.tx), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Single byte 0xA5: latency and bit pattern.
    drive(1'b1, 8'hA5);
    drive(1'b0, 8'h00);
    check("lat_tx_hi", 32'(bus.tx), 32'd1);
    check("lat_count", 32'(bus.fifo_count), 32'd1);
    check("lat_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      check("a5_bits", 32'(bus.tx), 32'(pat[i/CD]));
      if (i == FRAME - 1) check("a5_busy_stop", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    check("a5_busy_end", 32'(bus.busy), 32'd0);
    check("a5_rx", 32'(last_rx), 32'hA5);

    // Back-to-back frames.
    peak = 0;
    rx0  = rx_count;
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    drain();
    check("b2b_peak", 32'(peak), 32'd2);
    check("b2b_frames", 32'(rx_count - rx0), 32'd3);
    check("b2b_last", 32'(last_rx), 32'h03);

    // Overflow while a frame is in flight.
    rx0 = rx_count;
    drive(1'b1, 8'hEE);
    drive(1'b0, 8'h00);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h10 + i));
    drive(1'b0, 8'h00);
    check("ovf_count", 32'(bus.fifo_count), 32'd4);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    drain();
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_frames", 32'(rx_count - rx0), 32'd5);
    check("ovf_last", 32'(last_rx), 32'h13);
    do_reset();
    @(negedge clk);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Push at full on the STOP->START edge.
    drive(1'b1, 8'h30);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(8'h30 + i));
    drive(1'b0, 8'h00);
    check("full_count", 32'(bus.fifo_count), 32'd4);
    w = 0;
    while (frame_left != 1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("full_wait", 32'(w < 200), 32'd1);
    bus.in_byte_en = 1'b1;
    bus.in_byte    = 8'h77;
    @(negedge clk);
    bus.in_byte_en = 1'b0;
    check("full_push_count", 32'(bus.fifo_count), 32'd4);
    check("full_push_ovf", 32'(bus.overflow), 32'd0);
    drain();
    check("full_last", 32'(last_rx), 32'h77);
    check("full_ovf_end", 32'(bus.overflow), 32'd0);

    // Reset during data bit 3 of 0xFF.
    rx0 = rx_count;
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h5A);
    drive(1'b0, 8'h00);
    w = 0;
    while (frame_left != 22 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("mid_wait", 32'(w < 200), 32'd1);
    check("mid_pre_count", 32'(bus.fifo_count), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_tx", 32'(bus.tx), 32'd1);
    check("mid_count", 32'(bus.fifo_count), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_no_frames", 32'(rx_count - rx0), 32'd0);
    check("mid_idle_tx", 32'(bus.tx), 32'd1);

    // Randomized traffic with bursts.
    for (int i = 0; i < 800; i++) begin
      int thr;
      thr = ((i / 100) % 2 == 1) ? 40 : 6;
      drive(1'($urandom_range(0, 99) < thr), 8'($urandom));
    end
    drive(1'b0, 8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
